// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle CPU: fetch/decode/execute/writeback sequencing.
// Define COND_EXEC_EN to enable condition evaluation against an internal NZCV flags register.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] ALUFlags,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;

    logic [3:0] state_q, state_d;
    logic       cond_ex;

    function automatic logic [1:0] alu_dec(input logic [3:0] cmd);
        case (cmd)
            4'b0100: alu_dec = 2'b00;
            4'b0010: alu_dec = 2'b01;
            4'b0000: alu_dec = 2'b10;
            4'b1100: alu_dec = 2'b11;
            default: alu_dec = 2'b00;
        endcase
    endfunction

`ifdef COND_EXEC_EN
    logic [3:0] flags_q, flags_d;
    logic       n_f, z_f, c_f, v_f;

    assign {n_f, z_f, c_f, v_f} = flags_q;

    always_comb begin
        case (Cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = !z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = !c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = !n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = !v_f;
            4'b1000: cond_ex = c_f && !z_f;
            4'b1001: cond_ex = !c_f || z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = !z_f && (n_f == v_f);
            4'b1101: cond_ex = z_f || (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Flags load at the end of an S-bit execute; the next DECODE is at least two edges later.
    always_comb begin
        flags_d = flags_q;
        if ((state_q == S_EXECR || state_q == S_EXECI) && Funct[0]) begin
            flags_d = ALUFlags;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) flags_q <= 4'b0000;
        else       flags_q <= flags_d;
    end
`else
    logic unused_cond_inputs;
    assign unused_cond_inputs = ^{Cond, ALUFlags};
    assign cond_ex = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (!cond_ex || Op == 2'b11) state_d = S_FETCH;
                else if (Op == 2'b00)        state_d = Funct[5] ? S_EXECI : S_EXECR;
                else if (Op == 2'b01)        state_d = S_MEMADR;
                else                         state_d = S_BRANCH;
            end
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXECR,
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                illegal_op = (Op == 2'b11);
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc = 1'b1;
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_EXECR:  ALUControl = alu_dec(Funct[4:1]);
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec(Funct[4:1]);
            end
            S_ALUWB:  RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            default: ;
        endcase
        // Write enables must stay quiet during reset even though FETCH follows mem_ready.
        if (reset) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            illegal_op = 1'b0;
        end
    end

    always_comb begin
        case (Op)
            2'b01:   ImmSrc = 2'b01;
            2'b10:   ImmSrc = 2'b10;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign RegSrc = {Op == 2'b01, Op == 2'b10};
    assign state  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: expands each instruction into its expected
// state/mem_ready sequence from the latency rules and checks state and controls per cycle.
module tb_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] ALUFlags;
    logic       mem_ready;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc;
    logic       illegal_op;
    logic [3:0] state;

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] flags_m = 4'b0000;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct),
        .ALUFlags(ALUFlags), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
        .illegal_op(illegal_op), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit cond_ref(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic logic [1:0] alu_ref(input logic [3:0] cmd);
        if (cmd == 4'd4)       return 2'd0;
        else if (cmd == 4'd2)  return 2'd1;
        else if (cmd == 4'd0)  return 2'd2;
        else if (cmd == 4'd12) return 2'd3;
        return 2'd0;
    endfunction

    // {PCWrite,IRWrite,RegWrite,MemWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl,ImmSrc,RegSrc,illegal_op}
    function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input bit mr,
                                             input logic [1:0] op, input logic [5:0] fn, input bit rst);
        bit pcw = 0, irw = 0, regw = 0, memw = 0, adr = 0, srca = 0, ill = 0;
        logic [1:0] srcb = 0, res = 0, aluc = 0, imm, rs;
        case (st)
            4'd0: begin srca = 1; srcb = 2; res = 2; irw = mr; pcw = mr; end
            4'd1: begin srca = 1; srcb = 2; res = 2; ill = (op == 2'd3); end
            4'd2: srcb = 1;
            4'd3: adr = 1;
            4'd4: begin res = 1; regw = 1; end
            4'd5: begin adr = 1; memw = 1; end
            4'd6: aluc = alu_ref(fn[4:1]);
            4'd7: begin srcb = 1; aluc = alu_ref(fn[4:1]); end
            4'd8: regw = 1;
            4'd9: begin srcb = 1; res = 2; pcw = 1; end
            default: ;
        endcase
        imm = (op == 2'd1) ? 2'd1 : (op == 2'd2) ? 2'd2 : 2'd0;
        rs  = {op == 2'd1, op == 2'd2};
        if (rst) begin pcw = 0; irw = 0; regw = 0; memw = 0; ill = 0; end
        return {pcw, irw, regw, memw, adr, srca, srcb, res, aluc, imm, rs, ill};
    endfunction

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            reset = 1'b1; mem_ready = 1'b1; Op = 2'b11;
            #1;
            check("rst_we", {27'd0, PCWrite, IRWrite, RegWrite, MemWrite, illegal_op}, 32'd0);
            if (i == 1) check("rst_state", {28'd0, state}, 32'd0);
        end
        flags_m = 4'b0000;
    endtask

    task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                             input logic [3:0] af, input int abort_at);
        logic [3:0] sq[$];
        bit         mq[$];
        int         k;
        bit         ok;
        logic [3:0] tgt;
`ifdef COND_EXEC_EN
        ok = cond_ref(c, flags_m);
`else
        ok = 1'b1;
`endif
        k = $urandom_range(0, 2);
        repeat (k) begin sq.push_back(4'd0); mq.push_back(1'b0); end
        sq.push_back(4'd0); mq.push_back(1'b1);
        sq.push_back(4'd1); mq.push_back(1'($urandom_range(0, 1)));
        if (ok && op != 2'd3) begin
            case (op)
                2'd0: begin
                    sq.push_back(fn[5] ? 4'd7 : 4'd6); mq.push_back(1'($urandom_range(0, 1)));
                    sq.push_back(4'd8);                mq.push_back(1'($urandom_range(0, 1)));
                end
                2'd1: begin
                    sq.push_back(4'd2); mq.push_back(1'($urandom_range(0, 1)));
                    tgt = fn[0] ? 4'd3 : 4'd5;
                    k = $urandom_range(0, 2);
                    repeat (k) begin sq.push_back(tgt); mq.push_back(1'b0); end
                    sq.push_back(tgt); mq.push_back(1'b1);
                    if (fn[0]) begin sq.push_back(4'd4); mq.push_back(1'($urandom_range(0, 1))); end
                end
                default: begin
                    sq.push_back(4'd9); mq.push_back(1'($urandom_range(0, 1)));
                end
            endcase
        end
        for (int i = 0; i < sq.size(); i++) begin
            @(negedge clk);
            reset = (i == abort_at); mem_ready = mq[i];
            Cond = c; Op = op; Funct = fn; ALUFlags = af;
            #1;
            check("state", {28'd0, state}, {28'd0, sq[i]});
            check("ctrl", {15'd0, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
                           ResultSrc, ALUControl, ImmSrc, RegSrc, illegal_op},
                  {15'd0, exp_ctrl(sq[i], mq[i], op, fn, reset)});
            if (i == abort_at) begin
                flags_m = 4'b0000;
                break;
            end
            if ((sq[i] == 4'd6 || sq[i] == 4'd7) && fn[0]) flags_m = af;
        end
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b1; Cond = 4'hE; Op = 2'b00; Funct = 6'd0; ALUFlags = 4'd0;
        do_reset();
        run_instr(4'hE, 2'b00, 6'b101000, 4'd0, -1);   // ADD immediate
        run_instr(4'hE, 2'b01, 6'b011001, 4'd0, -1);   // LDR
        run_instr(4'hE, 2'b01, 6'b011000, 4'd0, -1);   // STR
        run_instr(4'hE, 2'b00, 6'b000101, 4'b0100, -1); // SUBS, Z=1
        run_instr(4'h0, 2'b10, 6'b000000, 4'd0, -1);   // BEQ
        run_instr(4'hE, 2'b00, 6'b001001, 4'b0000, -1); // ADDS, flags cleared
        run_instr(4'h0, 2'b00, 6'b001000, 4'd0, -1);   // ADDEQ
        run_instr(4'hF, 2'b00, 6'b001000, 4'd0, -1);
        run_instr(4'hE, 2'b11, 6'b000000, 4'd0, -1);   // undefined op
        run_instr(4'hE, 2'b00, 6'b001000, 4'd0, 3);    // reset mid-instruction
        for (int n = 0; n < 300; n++) begin
            logic [3:0] c;
            c = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            run_instr(c, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
                      4'($urandom_range(0, 15)),
                      ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : -1);
            if ($urandom_range(0, 40) == 0) do_reset();
        end
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b0;
        #1;
        check("final_state", {28'd0, state}, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
